// File: rtl/sub_bytes_lanes.sv
// rtl/sub_bytes_lanes.sv - multi-lane pipelined AES SubBytes/InvSubBytes unit
// S1 holds the registered S-box read, S2 is the elastic output register.
module sub_bytes_lanes #(
  parameter int NUM_LANES = 4,
  parameter int TAG_W     = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [8*NUM_LANES-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_LANES-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_inv,
  output logic                   busy
);
  localparam int DW = 8 * NUM_LANES;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [2047:0] build_inv();
    logic [2047:0] t;
    logic [7:0]    s;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      s = SBOX_FLAT[8*(255-i) +: 8];
      t[8*(255 - int'(s)) +: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX_FLAT = build_inv();

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FLAT[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return INV_SBOX_FLAT[8*(255 - int'(b)) +: 8];
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_inv_q, s1_inv_d;
  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_inv_q, s2_inv_d;

  logic             in_xfer;
  logic             out_xfer;
  logic             s2_load;
  logic [DW-1:0]    lut_data;

  always_comb begin
    in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
    out_valid = s2_valid_q && !Reset;
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    s2_load   = s1_valid_q && (!s2_valid_q || out_xfer);

    lut_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lut_data[8*i +: 8] = in_inv ? sbox_inv(in_data[8*i +: 8])
                                  : sbox_fwd(in_data[8*i +: 8]);
    end

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    s1_inv_d   = s1_inv_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_inv_d   = s2_inv_q;

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q;
      s2_tag_d   = s1_tag_q;
      s2_inv_d   = s1_inv_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    // The table read is only enabled on an input transfer, so a stalled S1 never re-reads.
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = lut_data;
      s1_tag_d   = in_tag;
      s1_inv_d   = in_inv;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_inv_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_inv_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s1_inv_q   <= s1_inv_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_inv_q   <= s2_inv_d;
    end
  end

  assign out_data = s2_data_q;
  assign out_tag  = s2_tag_q;
  assign out_inv  = s2_inv_q;
  assign busy     = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_sub_bytes_lanes.sv
// tb/tb_sub_bytes_lanes.sv - scoreboard bench for sub_bytes_lanes
// Reference S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_lanes;
  localparam int NL = 4;
  localparam int TW = 4;
  localparam int DW = 8 * NL;

  logic          Clk       = 1'b0;
  logic          Reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          in_inv    = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [TW-1:0] in_tag    = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_inv;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          inv;
  } txn_t;

  txn_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         ready_mode = 0;
  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref  [256];

  sub_bytes_lanes #(.NUM_LANES(NL), .TAG_W(TW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_inv   (out_inv),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      r[8*i +: 8] = inv ? inv_ref[d[8*i +: 8]] : sbox_ref[d[8*i +: 8]];
    return r;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic inv,
                      input logic [DW-1:0] expd, output int stalls);
    txn_t e;
    in_valid = 1'b1; in_data = d; in_tag = t; in_inv = inv;
    stalls = 0;
    forever begin
      @(negedge Clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 100) break;
    end
    if (stalls > 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", stalls);
      in_valid = 1'b0;
    end else begin
      @(posedge Clk);
      e.data = expd; e.tag = t; e.inv = inv;
      exp_q.push_back(e);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    int c;
    in_valid = 1'b0;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(negedge Clk);
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge Clk);
    #1;
  endtask

  initial forever begin
    @(posedge Clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, checks hold-stability and busy.
  initial begin
    logic held;
    txn_t held_t, got;
    held = 1'b0;
    held_t = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        held = 1'b0;
        continue;
      end
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_payload", 64'({out_data, out_tag, out_inv}), 64'(held_t));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: got %0h expected no output", out_data);
        end else begin
          got = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(got.data));
          chk("out_tag", 64'(out_tag), 64'(got.tag));
          chk("out_inv", 64'(out_inv), 64'(got.inv));
        end
      end
      held   = out_valid && !out_ready;
      held_t = {out_data, out_tag, out_inv};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int            st, total, stc;
    logic [7:0]    xi;
    logic [DW-1:0] d, e, da, db, dc;

    for (int x = 0; x < 256; x++) begin
      xi = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
      sbox_ref[x] = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_ref[sbox_ref[x]] = 8'(x);

    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_inv", 64'(out_inv), 64'd0);
    ready_mode = 1;
    @(posedge Clk);
    #1;

    send(32'h00015352, 4'h3, 1'b0, 32'h637ced00, st);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge Clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_cycle2_data", 64'(out_data), 64'h637ced00);
    @(posedge Clk);
    #1;
    send(32'h637ced00, 4'h9, 1'b1, 32'h00015352, st);
    send(32'h16ff7d63, 4'ha, 1'b1, 32'hff7d1300, st);
    drain();

    total = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < NL; i++) d[8*i +: 8] = 8'((k + i) % 256);
      send(d, 4'(k), 1'b0, model(d, 1'b0), st);
      total += st;
    end
    chk("stream_fwd_stalls", 64'(total), 64'd0);
    drain();

    total = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < NL; i++) begin
        e[8*i +: 8] = 8'((k + i) % 256);
        d[8*i +: 8] = sbox_ref[(k + i) % 256];
      end
      send(d, 4'(k + 7), 1'b1, e, st);
      total += st;
    end
    chk("stream_inv_stalls", 64'(total), 64'd0);
    drain();

    ready_mode = 0;
    @(posedge Clk);
    #1;
    da = $urandom; db = $urandom; dc = $urandom;
    send(da, 4'h1, 1'b0, model(da, 1'b0), st);
    chk("bp_first_stalls", 64'(st), 64'd0);
    send(db, 4'h2, 1'b1, model(db, 1'b1), st);
    chk("bp_second_stalls", 64'(st), 64'd0);
    fork
      send(dc, 4'h3, 1'b0, model(dc, 1'b0), stc);
      begin
        repeat (3) begin
          @(negedge Clk);
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        ready_mode = 1;
        @(negedge Clk);
        chk("bp_accept_with_output", 64'({in_ready, out_valid, out_ready}), 64'b111);
      end
    join
    chk("bp_third_stalls", 64'(stc), 64'd3);
    drain();

    ready_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      d = $urandom;
      in_tag = 4'($urandom);
      send(d, 4'($urandom), 1'($urandom_range(0, 1)), '0, st);
      exp_q[exp_q.size() - 1].data = model(d, exp_q[exp_q.size() - 1].inv);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    ready_mode = 1;
    drain();

    ready_mode = 0;
    @(posedge Clk);
    #1;
    da = $urandom; db = $urandom;
    send(da, 4'h4, 1'b1, model(da, 1'b1), st);
    send(db, 4'h6, 1'b0, model(db, 1'b0), st);
    Reset = 1'b1;
    in_valid = 1'b1; in_data = $urandom; in_inv = 1'b1; in_tag = 4'hf;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
    chk("mid_rst_out_inv", 64'(out_inv), 64'd0);
    ready_mode = 1;
    @(posedge Clk);
    #1;
    send(32'h00000000, 4'h5, 1'b0, 32'h63636363, st);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
